// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache controller. It has one read MSHR and one
// outstanding memory transaction, and it tracks a load-locked reservation for STC.
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = $clog2(NUM_LINES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsq2Dcache_ld_en_i,
   input  logic [63:0] lsq2Dcache_ld_addr_i,
   input  logic        lsq2Dcache_ldl_flag_i,
   input  logic        lsq2Dcache_st_en_i,
   input  logic [63:0] lsq2Dcache_st_addr_i,
   input  logic [63:0] lsq2Dcache_st_data_i,
   input  logic        lsq2Dcache_stc_flag_i,
   input  logic        bus_inv_vld_i,
   input  logic [63:0] bus_inv_addr_i,
   input  logic        mem_gnt_i,
   input  logic        mem_rsp_vld_i,
   input  logic [63:0] mem_rsp_data_i,
   output logic        Dcache_hit_o,
   output logic [63:0] Dcache_data_o,
   output logic [63:0] Dcache_mshr_addr_o,
   output logic        Dcache_mshr_ld_ack_o,
   output logic        Dcache_mshr_st_ack_o,
   output logic        Dcache_mshr_vld_o,
   output logic        Dcache_mshr_stall_o,
   output logic        Dcache_stc_success_o,
   output logic        Dcache_stc_fail_o,
   output logic        mem_req_o,
   output logic        mem_wr_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wr_data_o
);
   localparam int TAG_W = 64 - 3 - IDX_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      FILL    = 3'd3,
      WR_REQ  = 3'd4
   } state_t;

   function automatic logic [63:0] align8(input logic [63:0] addr);
      return addr & ~64'd7;
   endfunction

   state_t state;
   state_t state_next;

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tag_arr [NUM_LINES];
   logic [63:0]          data_arr [NUM_LINES];

   logic [63:0] mshr_addr;
   logic [63:0] fill_data;
   logic [63:0] mem_addr;
   logic [63:0] mem_wr_data;
   logic [63:0] lock_addr;
   logic        lock_vld;
   logic        snoop_kill;

   logic [63:0]      ld_aligned, st_aligned, inv_aligned, lock_addr_next;
   logic [IDX_W-1:0] ld_idx, st_idx, inv_idx, mshr_idx;
   logic [TAG_W-1:0] ld_tag, st_tag, inv_tag, mshr_tag;
   logic ld_hit_raw, st_hit, inv_hit, stc_ok, idle;
   logic st_acc, stc_succ, stc_fail, ld_acc, hit, kill_now;
   logic lock_set, lock_clr;

   // Address decode, hit detection and request arbitration
   always_comb begin
      ld_aligned  = align8(lsq2Dcache_ld_addr_i);
      st_aligned  = align8(lsq2Dcache_st_addr_i);
      inv_aligned = align8(bus_inv_addr_i);
      ld_idx      = lsq2Dcache_ld_addr_i[3+IDX_W-1:3];
      st_idx      = lsq2Dcache_st_addr_i[3+IDX_W-1:3];
      inv_idx     = bus_inv_addr_i[3+IDX_W-1:3];
      mshr_idx    = mshr_addr[3+IDX_W-1:3];
      ld_tag      = lsq2Dcache_ld_addr_i[63:3+IDX_W];
      st_tag      = lsq2Dcache_st_addr_i[63:3+IDX_W];
      inv_tag     = bus_inv_addr_i[63:3+IDX_W];
      mshr_tag    = mshr_addr[63:3+IDX_W];

      ld_hit_raw = lsq2Dcache_ld_en_i && valid[ld_idx] && (tag_arr[ld_idx] == ld_tag);
      st_hit     = valid[st_idx] && (tag_arr[st_idx] == st_tag);
      inv_hit    = bus_inv_vld_i && valid[inv_idx] && (tag_arr[inv_idx] == inv_tag);
      stc_ok     = lock_vld && (lock_addr == st_aligned);
      idle       = (state == IDLE);

      st_acc   = 1'b0;
      stc_succ = 1'b0;
      stc_fail = 1'b0;
      if (idle && lsq2Dcache_st_en_i) begin
         if (lsq2Dcache_stc_flag_i) begin
            if (stc_ok) begin
               st_acc   = 1'b1;
               stc_succ = 1'b1;
            end else begin
               stc_fail = 1'b1;
            end
         end else begin
            st_acc = 1'b1;
         end
      end else begin
         st_acc = 1'b0;
      end

      ld_acc = idle && lsq2Dcache_ld_en_i && !ld_hit_raw && !st_acc;
      hit    = ld_hit_raw && (state != FILL);
      // A snoop of the line in flight must not let a stale fill be installed
      kill_now = bus_inv_vld_i && (inv_aligned == mshr_addr) &&
                 ((state == RD_REQ) || (state == RD_WAIT) || (state == FILL));

      lock_set       = lsq2Dcache_ldl_flag_i && (hit || ld_acc);
      lock_addr_next = lock_set ? ld_aligned : lock_addr;
      lock_clr       = (st_acc && (st_aligned == lock_addr_next)) ||
                       (bus_inv_vld_i && (inv_aligned == lock_addr_next));
   end

   // Memory-port sequencing
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (st_acc)      state_next = WR_REQ;
            else if (ld_acc) state_next = RD_REQ;
            else             state_next = IDLE;
         end
         RD_REQ:  state_next = mem_gnt_i ? RD_WAIT : RD_REQ;
         RD_WAIT: state_next = mem_rsp_vld_i ? FILL : RD_WAIT;
         FILL:    state_next = IDLE;
         WR_REQ:  state_next = mem_gnt_i ? IDLE : WR_REQ;
         default: state_next = IDLE;
      endcase
   end

   // Control state, valid bits, MSHR and reservation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         valid       <= '0;
         mshr_addr   <= 64'd0;
         fill_data   <= 64'd0;
         mem_addr    <= 64'd0;
         mem_wr_data <= 64'd0;
         lock_addr   <= 64'd0;
         lock_vld    <= 1'b0;
         snoop_kill  <= 1'b0;
      end else begin
         state <= state_next;
         if (inv_hit) valid[inv_idx] <= 1'b0;
         if ((state == FILL) && !snoop_kill && !kill_now) valid[mshr_idx] <= 1'b1;
         if (st_acc) begin
            mem_addr    <= st_aligned;
            mem_wr_data <= lsq2Dcache_st_data_i;
         end else if (ld_acc) begin
            mem_addr  <= ld_aligned;
            mshr_addr <= ld_aligned;
         end
         if (ld_acc) snoop_kill <= 1'b0;
         else if (kill_now) snoop_kill <= 1'b1;
         if ((state == RD_WAIT) && mem_rsp_vld_i) fill_data <= mem_rsp_data_i;
         lock_addr <= lock_addr_next;
         if (lock_clr) lock_vld <= 1'b0;
         else if (lock_set) lock_vld <= 1'b1;
      end
   end

   // Tag and data arrays; contents are qualified by valid, so no reset is needed
   always_ff @(posedge clk) begin
      if ((state == FILL) && !snoop_kill && !kill_now) begin
         tag_arr[mshr_idx]  <= mshr_tag;
         data_arr[mshr_idx] <= fill_data;
      end else if (st_acc && st_hit) begin
         data_arr[st_idx] <= lsq2Dcache_st_data_i;
      end
   end

   // Outputs are held at zero while reset is asserted
   always_comb begin
      Dcache_hit_o         = rst && hit;
      Dcache_mshr_ld_ack_o = rst && ld_acc;
      Dcache_mshr_st_ack_o = rst && st_acc;
      Dcache_stc_success_o = rst && stc_succ;
      Dcache_stc_fail_o    = rst && stc_fail;
      Dcache_mshr_vld_o    = rst && (state == FILL);
      Dcache_mshr_stall_o  = rst && (state != IDLE);
      mem_req_o            = rst && ((state == RD_REQ) || (state == WR_REQ));
      mem_wr_o             = rst && (state == WR_REQ);
      mem_addr_o           = mem_addr;
      mem_wr_data_o        = mem_wr_data;
      Dcache_mshr_addr_o   = mshr_addr;
      if (!rst) begin
         Dcache_data_o = 64'd0;
      end else if (state == FILL) begin
         Dcache_data_o = fill_data;
      end else if (hit) begin
         Dcache_data_o = data_arr[ld_idx];
      end else begin
         Dcache_data_o = 64'd0;
      end
   end
endmodule
